player_motion_ctrl: RTL and testbench

Per-frame player kinematics controller, the stage directly downstream of platform collision detection. It consumes the collision flags and `support_y` that the collision stage derives from the current player position. Once per video frame it updates the registered `player_x` and `player_y`, which feed back to the collision stage and to the renderer. It owns gravity, walking, jumping, landing snap, lava death with a respawn delay, and goal latching.

---
 rtl/game_pkg.sv | 26 ++
 rtl/frame_down_counter.sv | 27 ++
 rtl/player_motion_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: sprite size, screen limits, spawn table and the
// player motion state encoding used by collision, motion and render stages.
package game_pkg;

  localparam int PLAYER_W = 16;
  localparam int PLAYER_H = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_SPAWN_X    = 20;
  localparam int DEF_SPAWN_Y_L0 = 344;
  localparam int DEF_SPAWN_Y_L1 = 384;

  typedef enum logic [2:0] {
    SPAWN    = 3'd0,
    GROUNDED = 3'd1,
    AIRBORNE = 3'd2,
    DEAD     = 3'd3,
    GOAL     = 3'd4
  } motion_state_t;

  function automatic logic [9:0] spawn_y(input logic [1:0] level);
    return (level == 2'd0) ? 10'(DEF_SPAWN_Y_L0) : 10'(DEF_SPAWN_Y_L1);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter advanced by frame ticks; holds at zero.
module frame_down_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player kinematics: walk, jump, gravity, landing, lava death, goal.
// Optional walk-off jump grace window enabled by `define PLAYER_COYOTE_TIME_EN.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int SPAWN_X        = DEF_SPAWN_X,
  parameter int SPAWN_Y_L0     = DEF_SPAWN_Y_L0,
  parameter int SPAWN_Y_L1     = DEF_SPAWN_Y_L1,
  parameter int WALK_SPEED     = 2,
  parameter int JUMP_VEL       = 10,
  parameter int GRAVITY        = 1,
  parameter int MAX_FALL       = 8,
  parameter int RESPAWN_FRAMES = 60,
  parameter int X_MAX          = SCREEN_W - PLAYER_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  input  logic [1:0]        level,
  input  logic              on_ground,
  input  logic [9:0]        support_y,
  input  logic              hit_ceiling,
  input  logic              hit_left_wall,
  input  logic              hit_right_wall,
  input  logic              at_goal_region,
  input  logic              in_lava,
  output logic [9:0]        player_x,
  output logic [9:0]        player_y,
  output logic signed [5:0] vel_y,
  output logic [2:0]        state,
  output logic              level_done,
  output logic              died,
  output logic [7:0]        death_count
);

  localparam int unsigned CNT_W = (RESPAWN_FRAMES > 2) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic signed [10:0] WALK_S = 11'(WALK_SPEED);
  localparam logic signed [10:0] JUMP_S = 11'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_S = 11'(MAX_FALL);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMAX_S = 11'(SCREEN_H - PLAYER_H - 1);
  localparam logic signed [10:0] PH_S   = 11'(PLAYER_H);
  localparam logic signed [5:0]  JUMP_V = 6'(-JUMP_VEL);

  motion_state_t     state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [7:0]        deaths_q, deaths_d;
  logic [1:0]        goal_level_q, goal_level_d;
  logic              done_d, died_d, dead_load, dead_zero;
  logic              take_jump, apply_y, coyote_jump;
  logic signed [10:0] x_ext, y_ext, sup_ext, vel_ext, x_calc, y_calc, v_calc;

  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {1'b0, y_q};
  assign sup_ext = {1'b0, support_y};
  assign vel_ext = {{5{vel_q[5]}}, vel_q};

`ifdef PLAYER_COYOTE_TIME_EN
  logic [2:0] coyote_q, coyote_d;
  assign coyote_jump = btn_jump && (coyote_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coyote_q <= '0;
    else if (frame_tick) coyote_q <= coyote_d;
  end
`else
  assign coyote_jump = 1'b0;
`endif

  frame_down_counter #(.WIDTH(CNT_W)) u_respawn (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (frame_tick && dead_load),
    .load_value (CNT_W'(RESPAWN_FRAMES - 1)),
    .tick       (frame_tick && state_q == DEAD),
    .zero       (dead_zero)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vel_d        = vel_q;
    deaths_d     = deaths_q;
    goal_level_d = goal_level_q;
    done_d       = 1'b0;
    died_d       = 1'b0;
    dead_load    = 1'b0;
    take_jump    = 1'b0;
    apply_y      = 1'b0;
    y_calc       = y_ext;
    v_calc       = vel_ext;
    x_calc       = x_ext;
`ifdef PLAYER_COYOTE_TIME_EN
    coyote_d     = coyote_q;
`endif
    if (btn_right && !btn_left && !hit_right_wall)      x_calc = x_ext + WALK_S;
    else if (btn_left && !btn_right && !hit_left_wall)  x_calc = x_ext - WALK_S;

    case (state_q)
      SPAWN: begin
        x_d     = 10'(SPAWN_X);
        y_d     = (level == 2'd0) ? 10'(SPAWN_Y_L0) : 10'(SPAWN_Y_L1);
        vel_d   = '0;
        state_d = AIRBORNE;
`ifdef PLAYER_COYOTE_TIME_EN
        coyote_d = '0;
`endif
      end
      GROUNDED, AIRBORNE: begin
        if (in_lava) begin
          state_d   = DEAD;
          died_d    = 1'b1;
          dead_load = 1'b1;
          vel_d     = '0;
          if (deaths_q != 8'hFF) deaths_d = deaths_q + 8'd1;
        end else if (at_goal_region) begin
          state_d      = GOAL;
          done_d       = 1'b1;
          goal_level_d = level;
        end else begin
          if (x_calc[10])          x_d = '0;
          else if (x_calc > XMAX_S) x_d = XMAX_S[9:0];
          else                      x_d = x_calc[9:0];

          if (state_q == GROUNDED) begin
            if (btn_jump) begin
              take_jump = 1'b1;
            end else if (!on_ground) begin
              state_d = AIRBORNE;
              vel_d   = '0;
`ifdef PLAYER_COYOTE_TIME_EN
              coyote_d = 3'd4;
`endif
            end else begin
              y_calc  = sup_ext - PH_S;
              apply_y = 1'b1;
            end
          end else begin
`ifdef PLAYER_COYOTE_TIME_EN
            if (coyote_q != '0) coyote_d = coyote_q - 3'd1;
`endif
            if (coyote_jump) begin
              take_jump = 1'b1;
            end else if (hit_ceiling && vel_q[5]) begin
              vel_d = '0;
            end else if (on_ground && !vel_q[5]) begin
              y_calc  = sup_ext - PH_S;
              vel_d   = '0;
              apply_y = 1'b1;
              state_d = GROUNDED;
`ifdef PLAYER_COYOTE_TIME_EN
              coyote_d = '0;
`endif
            end else begin
              v_calc = vel_ext + GRAV_S;
              if (v_calc > MAXF_S) v_calc = MAXF_S;
              vel_d   = v_calc[5:0];
              y_calc  = y_ext + v_calc;
              apply_y = 1'b1;
            end
          end
        end
      end
      DEAD:    if (dead_zero) state_d = SPAWN;
      GOAL:    if (level != goal_level_q) state_d = SPAWN;
      default: state_d = SPAWN;
    endcase

    // Jump from either the ground or the grace window shares one path.
    if (take_jump) begin
      vel_d   = JUMP_V;
      y_calc  = y_ext - JUMP_S;
      apply_y = 1'b1;
      state_d = AIRBORNE;
`ifdef PLAYER_COYOTE_TIME_EN
      coyote_d = '0;
`endif
    end

    if (apply_y) begin
      if (y_calc[10]) begin
        y_d   = '0;
        vel_d = '0;
      end else if (y_calc > YMAX_S) begin
        y_d = YMAX_S[9:0];
      end else begin
        y_d = y_calc[9:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SPAWN;
      x_q          <= 10'(SPAWN_X);
      y_q          <= 10'(SPAWN_Y_L0);
      vel_q        <= '0;
      deaths_q     <= '0;
      goal_level_q <= '0;
      level_done   <= 1'b0;
      died         <= 1'b0;
    end else begin
      level_done <= frame_tick & done_d;
      died       <= frame_tick & died_d;
      if (frame_tick) begin
        state_q      <= state_d;
        x_q          <= x_d;
        y_q          <= y_d;
        vel_q        <= vel_d;
        deaths_q     <= deaths_d;
        goal_level_q <= goal_level_d;
      end
    end
  end

  assign player_x    = x_q;
  assign player_y    = y_q;
  assign vel_y       = vel_q;
  assign state       = state_q;
  assign death_count = deaths_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed-vector bench for player_motion_ctrl with hand-computed expectations.
module tb_player_motion_ctrl;

  logic              clk = 1'b0;
  logic              rst_n, frame_tick, btn_left, btn_right, btn_jump;
  logic [1:0]        level;
  logic              on_ground, hit_ceiling, hit_left_wall, hit_right_wall;
  logic              at_goal_region, in_lava;
  logic [9:0]        support_y;
  logic [9:0]        player_x, player_y;
  logic signed [5:0] vel_y;
  logic [2:0]        state;
  logic              level_done, died;
  logic [7:0]        death_count;

  int checks = 0;
  int errors = 0;
  int ey, ev;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_jump       (btn_jump),
    .level          (level),
    .on_ground      (on_ground),
    .support_y      (support_y),
    .hit_ceiling    (hit_ceiling),
    .hit_left_wall  (hit_left_wall),
    .hit_right_wall (hit_right_wall),
    .at_goal_region (at_goal_region),
    .in_lava        (in_lava),
    .player_x       (player_x),
    .player_y       (player_y),
    .vel_y          (vel_y),
    .state          (state),
    .level_done     (level_done),
    .died           (died),
    .death_count    (death_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    level = 2'd0; on_ground = 1'b0; support_y = '0;
    hit_ceiling = 1'b0; hit_left_wall = 1'b0; hit_right_wall = 1'b0;
    at_goal_region = 1'b0; in_lava = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_x", int'(player_x), 20);
    check("rst_y", int'(player_y), 344);
    check("rst_vel", int'(vel_y), 0);
    check("rst_deaths", int'(death_count), 0);
    check("rst_died", int'(died), 0);
    check("rst_done", int'(level_done), 0);
    rst_n = 1'b1;

    tick();
    check("spawn_state", int'(state), 2);
    check("spawn_x", int'(player_x), 20);
    check("spawn_y", int'(player_y), 344);

    on_ground = 1'b1; support_y = 10'd360;
    tick();
    check("land_state", int'(state), 1);
    check("land_y", int'(player_y), 344);

    btn_jump = 1'b1;
    tick();
    check("jump_state", int'(state), 2);
    check("jump_y", int'(player_y), 334);
    check("jump_vel", int'(vel_y), -10);
    btn_jump = 1'b0; on_ground = 1'b0;
    ey = 334; ev = -10;
    for (int i = 0; i < 10; i++) begin
      tick();
      ev = ev + 1;
      ey = ey + ev;
      check("rise_y", int'(player_y), ey);
      check("rise_vel", int'(vel_y), ev);
    end
    check("apex_y", int'(player_y), 289);
    check("apex_vel", int'(vel_y), 0);

    on_ground = 1'b1;
    tick();
    check("reland_state", int'(state), 1);
    check("reland_y", int'(player_y), 344);
    btn_jump = 1'b1;
    tick();
    btn_jump = 1'b0; on_ground = 1'b0;
    repeat (4) tick();
    check("pre_ceil_vel", int'(vel_y), -6);
    check("pre_ceil_y", int'(player_y), 304);
    hit_ceiling = 1'b1;
    tick();
    hit_ceiling = 1'b0;
    check("ceil_vel", int'(vel_y), 0);
    check("ceil_y", int'(player_y), 304);
    ey = 304; ev = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ev = (ev + 1 > 8) ? 8 : ev + 1;
      ey = ey + ev;
      check("fall_vel", int'(vel_y), ev);
    end
    check("fall_cap_vel", int'(vel_y), 8);
    check("fall_y", int'(player_y), 356);

    on_ground = 1'b1;
    tick();
    check("land2_state", int'(state), 1);
    check("land2_y", int'(player_y), 344);

    btn_right = 1'b1;
    repeat (40) tick();
    check("walk_x100", int'(player_x), 100);
    hit_right_wall = 1'b1;
    tick();
    check("wall_x", int'(player_x), 100);
    hit_right_wall = 1'b0;
    repeat (261) tick();
    check("walk_x622", int'(player_x), 622);
    tick();
    check("clamp_x", int'(player_x), 623);
    tick();
    check("clamp_hold_x", int'(player_x), 623);
    btn_left = 1'b1;
    tick();
    check("both_x", int'(player_x), 623);
    btn_right = 1'b0;
    tick();
    check("left_x", int'(player_x), 621);
    btn_left = 1'b0;

    in_lava = 1'b1; at_goal_region = 1'b1;
    tick();
    check("lava_state", int'(state), 3);
    check("lava_died", int'(died), 1);
    check("lava_done", int'(level_done), 0);
    check("lava_deaths", int'(death_count), 1);
    check("lava_x", int'(player_x), 621);
    check("lava_y", int'(player_y), 344);
    @(negedge clk);
    check("died_pulse", int'(died), 0);
    in_lava = 1'b0; at_goal_region = 1'b0; on_ground = 1'b0;
    level = 2'd1;
    repeat (59) tick();
    check("dead_hold", int'(state), 3);
    tick();
    check("respawn_state", int'(state), 0);
    tick();
    check("respawn_air", int'(state), 2);
    check("respawn_x", int'(player_x), 20);
    check("respawn_y_l1", int'(player_y), 384);

    at_goal_region = 1'b1;
    tick();
    check("goal_state", int'(state), 4);
    check("goal_done", int'(level_done), 1);
    @(negedge clk);
    check("done_pulse", int'(level_done), 0);
    at_goal_region = 1'b0;
    tick();
    check("goal_hold", int'(state), 4);
    level = 2'd2;
    tick();
    check("goal_exit", int'(state), 0);
    tick();
    check("l2_spawn_y", int'(player_y), 384);

    on_ground = 1'b1; support_y = 10'd400;
    tick();
    check("l2_land", int'(state), 1);
    on_ground = 1'b0;
    tick();
    check("walkoff_state", int'(state), 2);
    check("walkoff_vel", int'(vel_y), 0);
    tick();
    tick();
    check("coast_y", int'(player_y), 387);
    btn_jump = 1'b1;
    tick();
    btn_jump = 1'b0;
`ifdef PLAYER_COYOTE_TIME_EN
    check("coyote_vel", int'(vel_y), -10);
    check("coyote_y", int'(player_y), 377);
`else
    check("no_coyote_vel", int'(vel_y), 3);
    check("no_coyote_y", int'(player_y), 390);
`endif

    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_x", int'(player_x), 20);
    check("async_rst_y", int'(player_y), 344);
    check("async_rst_deaths", int'(death_count), 0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
